// File: rtl/simple_bus_xbar.sv
// Fixed-priority request crossbar with registered single-cycle response routing.
// Define SIMPLE_BUS_UNMAPPED_ERR_EN to answer unmapped requests with an error response.
module simple_bus_xbar #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                       host_err_o,
    output logic [NrDevices-1:0]                     device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices-1:0]                     device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
    input  logic [NrDevices-1:0]                     device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices-1:0]                     device_err_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int BeW      = DataWidth / 8;

    logic                    any_req;
    logic [HostIdxW-1:0]     host_sel;
    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeW-1:0]          sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    logic                    dev_hit;
    logic [DevIdxW-1:0]      dev_sel;
    logic                    dev_route;
    logic                    unmapped;

    logic                    pending_q;
    logic [HostIdxW-1:0]     host_q;
    logic [DevIdxW-1:0]      dev_q;
    logic                    unmapped_q;

    logic                    rsp_valid;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_err;

    // Lowest-index requester wins; the loop keeps only the first hit.
    always_comb begin
        any_req    = 1'b0;
        host_sel   = '0;
        host_gnt_o = '0;
        sel_addr   = '0;
        sel_we     = 1'b0;
        sel_be     = '0;
        sel_wdata  = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (host_req_i[h] && !any_req) begin
                any_req       = 1'b1;
                host_sel      = HostIdxW'(h);
                host_gnt_o[h] = 1'b1;
                sel_addr      = host_addr_i[h];
                sel_we        = host_we_i[h];
                sel_be        = host_be_i[h];
                sel_wdata     = host_wdata_i[h];
            end
        end
    end

    // Without a match dev_sel stays at 0, which is the fallback route.
    always_comb begin
        dev_hit = 1'b0;
        dev_sel = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) && !dev_hit) begin
                dev_hit = 1'b1;
                dev_sel = DevIdxW'(d);
            end
        end
    end

`ifdef SIMPLE_BUS_UNMAPPED_ERR_EN
    assign dev_route = any_req & dev_hit;
    assign unmapped  = any_req & ~dev_hit;
`else
    assign dev_route = any_req;
    assign unmapped  = 1'b0;
`endif

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = dev_route && (dev_sel == DevIdxW'(d));
            device_addr_o[d]  = sel_addr;
            device_we_o[d]    = sel_we;
            device_be_o[d]    = sel_be;
            device_wdata_o[d] = sel_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= 1'b0;
            host_q     <= '0;
            dev_q      <= '0;
            unmapped_q <= 1'b0;
        end else begin
            pending_q <= any_req;
            if (any_req) begin
                host_q     <= host_sel;
                dev_q      <= dev_sel;
                unmapped_q <= unmapped;
            end
        end
    end

    // An unmapped request answers itself: valid with error and zero data.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (dev_q == DevIdxW'(d)) begin
                rsp_valid = device_rvalid_i[d];
                rsp_rdata = device_rdata_i[d];
                rsp_err   = device_err_i[d];
            end
        end
        if (unmapped_q) begin
            rsp_valid = 1'b1;
            rsp_rdata = '0;
            rsp_err   = 1'b1;
        end
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (pending_q && (host_q == HostIdxW'(h))) begin
                host_rvalid_o[h] = rsp_valid;
                host_rdata_o[h]  = rsp_rdata;
                host_err_o[h]    = rsp_err;
            end
        end
    end
endmodule

// File: tb/tb_simple_bus_xbar.sv
// Directed bench for simple_bus_xbar: two hosts, RAM / SimCtrl / Timer map.
// Expectations follow SIMPLE_BUS_UNMAPPED_ERR_EN when it is defined.
module tb_simple_bus_xbar;
    localparam int NH = 2;
    localparam int ND = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NH-1:0]        host_req_i;
    logic [NH-1:0]        host_gnt_o;
    logic [NH-1:0][31:0]  host_addr_i;
    logic [NH-1:0]        host_we_i;
    logic [NH-1:0][3:0]   host_be_i;
    logic [NH-1:0][31:0]  host_wdata_i;
    logic [NH-1:0]        host_rvalid_o;
    logic [NH-1:0][31:0]  host_rdata_o;
    logic [NH-1:0]        host_err_o;
    logic [ND-1:0]        device_req_o;
    logic [ND-1:0][31:0]  device_addr_o;
    logic [ND-1:0]        device_we_o;
    logic [ND-1:0][3:0]   device_be_o;
    logic [ND-1:0][31:0]  device_wdata_o;
    logic [ND-1:0]        device_rvalid_i;
    logic [ND-1:0][31:0]  device_rdata_i;
    logic [ND-1:0]        device_err_i;
    logic [ND-1:0][31:0]  cfg_device_addr_base;
    logic [ND-1:0][31:0]  cfg_device_addr_mask;

    int checks = 0;
    int errors = 0;

    simple_bus_xbar #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        host_req_i      = '0;
        host_addr_i     = '0;
        host_we_i       = '0;
        host_be_i       = '0;
        host_wdata_i    = '0;
        device_rvalid_i = '0;
        device_rdata_i  = '0;
        device_err_i    = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        device_rvalid_i = 3'b111;
        #2;
        checks++; if (host_rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", host_rvalid_o); end
        checks++; if (host_err_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", host_err_o); end
        checks++; if (host_gnt_o !== 2'b00 || device_req_o !== 3'b000) begin errors++; $display("FAIL reset_idle gnt %b dreq %b exp 00/000", host_gnt_o, device_req_o); end
        checks++; if (device_addr_o[1] !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", device_addr_o[1]); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge clk_i);
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0010_0010; host_we_i[0] = 1'b1;
        host_be_i[0] = 4'hF; host_wdata_i[0] = 32'hDEAD_BEEF;
        #1;
        checks++; if (host_gnt_o !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b exp 01", host_gnt_o); end
        checks++; if (device_req_o !== 3'b001) begin errors++; $display("FAIL wr_dreq got %b exp 001", device_req_o); end
        checks++; if (device_addr_o[0] !== 32'h0010_0010 || device_wdata_o[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_fwd addr %h wdata %h exp 00100010/deadbeef", device_addr_o[0], device_wdata_o[0]); end
        checks++; if (device_we_o[0] !== 1'b1 || device_be_o[0] !== 4'hF) begin errors++; $display("FAIL wr_webe we %b be %h exp 1/f", device_we_o[0], device_be_o[0]); end
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i[0] = 1'b1;
        #1;
        checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b00) begin errors++; $display("FAIL wr_rsp rvalid %b err %b exp 01/00", host_rvalid_o, host_err_o); end
    endtask

    task automatic test_timer_err();
        @(negedge clk_i);
        idle_inputs();
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0003_0004;
        #1;
        checks++; if (device_req_o !== 3'b100) begin errors++; $display("FAIL tmr_dreq got %b exp 100", device_req_o); end
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i[2] = 1'b1; device_rdata_i[2] = 32'h1234; device_err_i[2] = 1'b1;
        #1;
        checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b01) begin errors++; $display("FAIL tmr_rsp rvalid %b err %b exp 01/01", host_rvalid_o, host_err_o); end
        checks++; if (host_rdata_o[0] !== 32'h1234) begin errors++; $display("FAIL tmr_rdata got %h exp 1234", host_rdata_o[0]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        idle_inputs();
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0010_0000;
        #1;
        checks++; if (device_req_o !== 3'b001) begin errors++; $display("FAIL b2b_dreq0 got %b exp 001", device_req_o); end
        @(negedge clk_i);
        host_addr_i[0] = 32'h0002_0008;
        device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'hAAAA;
        #1;
        checks++; if (host_gnt_o !== 2'b01 || device_req_o !== 3'b010) begin errors++; $display("FAIL b2b_dreq1 gnt %b dreq %b exp 01/010", host_gnt_o, device_req_o); end
        checks++; if (host_rvalid_o !== 2'b01 || host_rdata_o[0] !== 32'hAAAA) begin errors++; $display("FAIL b2b_rsp0 rvalid %b rdata %h exp 01/aaaa", host_rvalid_o, host_rdata_o[0]); end
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i = 3'b011; device_rdata_i[0] = 32'hCCCC; device_rdata_i[1] = 32'hBBBB;
        #1;
        checks++; if (host_rvalid_o !== 2'b01 || host_rdata_o[0] !== 32'hBBBB) begin errors++; $display("FAIL b2b_rsp1 rvalid %b rdata %h exp 01/bbbb", host_rvalid_o, host_rdata_o[0]); end
    endtask

    task automatic test_two_hosts();
        @(negedge clk_i);
        idle_inputs();
        host_req_i = 2'b11; host_addr_i[0] = 32'h0010_0000; host_addr_i[1] = 32'h0002_0000;
        #1;
        checks++; if (host_gnt_o !== 2'b01 || device_req_o !== 3'b001) begin errors++; $display("FAIL arb_first gnt %b dreq %b exp 01/001", host_gnt_o, device_req_o); end
        checks++; if (device_addr_o[0] !== 32'h0010_0000) begin errors++; $display("FAIL arb_addr got %h exp 00100000", device_addr_o[0]); end
        @(negedge clk_i);
        host_req_i = 2'b10;
        device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h11;
        #1;
        checks++; if (host_gnt_o !== 2'b10 || device_req_o !== 3'b010) begin errors++; $display("FAIL arb_second gnt %b dreq %b exp 10/010", host_gnt_o, device_req_o); end
        checks++; if (host_rvalid_o !== 2'b01 || host_rdata_o[0] !== 32'h11) begin errors++; $display("FAIL arb_rsp0 rvalid %b rdata %h exp 01/11", host_rvalid_o, host_rdata_o[0]); end
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i[1] = 1'b1; device_rdata_i[1] = 32'h22;
        #1;
        checks++; if (host_rvalid_o !== 2'b10 || host_rdata_o[1] !== 32'h22) begin errors++; $display("FAIL arb_rsp1 rvalid %b rdata %h exp 10/22", host_rvalid_o, host_rdata_o[1]); end
        checks++; if (host_rdata_o[0] !== 32'h0) begin errors++; $display("FAIL arb_iso rdata0 %h exp 0", host_rdata_o[0]); end
    endtask

    task automatic test_unmapped();
        @(negedge clk_i);
        idle_inputs();
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0005_0000;
        #1;
        checks++; if (host_gnt_o !== 2'b01) begin errors++; $display("FAIL unm_gnt got %b exp 01", host_gnt_o); end
`ifdef SIMPLE_BUS_UNMAPPED_ERR_EN
        checks++; if (device_req_o !== 3'b000) begin errors++; $display("FAIL unm_dreq got %b exp 000", device_req_o); end
`else
        checks++; if (device_req_o !== 3'b001) begin errors++; $display("FAIL unm_dreq got %b exp 001", device_req_o); end
`endif
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h77;
        #1;
`ifdef SIMPLE_BUS_UNMAPPED_ERR_EN
        checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b01 || host_rdata_o[0] !== 32'h0) begin errors++; $display("FAIL unm_rsp rvalid %b err %b rdata %h exp 01/01/0", host_rvalid_o, host_err_o, host_rdata_o[0]); end
`else
        checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b00 || host_rdata_o[0] !== 32'h77) begin errors++; $display("FAIL unm_rsp rvalid %b err %b rdata %h exp 01/00/77", host_rvalid_o, host_err_o, host_rdata_o[0]); end
`endif
    endtask

    task automatic test_idle_clears();
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h55;
        #1;
        checks++; if (host_rvalid_o !== 2'b00 || host_rdata_o[0] !== 32'h0) begin errors++; $display("FAIL idle_rsp rvalid %b rdata %h exp 00/0", host_rvalid_o, host_rdata_o[0]); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk_i);
        idle_inputs();
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0010_0000;
        @(negedge clk_i);
        idle_inputs();
        device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h99;
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (host_rvalid_o !== 2'b00 || host_rdata_o[0] !== 32'h0) begin errors++; $display("FAIL mrst_drop rvalid %b rdata %h exp 00/0", host_rvalid_o, host_rdata_o[0]); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        #1;
        checks++; if (host_gnt_o !== 2'b00 || device_req_o !== 3'b000 || host_rvalid_o !== 2'b00 || host_err_o !== 2'b00) begin errors++; $display("FAIL mrst_idle gnt %b dreq %b rvalid %b err %b exp all 0", host_gnt_o, device_req_o, host_rvalid_o, host_err_o); end
        checks++; if (device_addr_o[0] !== 32'h0 || host_rdata_o !== '0) begin errors++; $display("FAIL mrst_data addr %h rdata0 %h exp 0", device_addr_o[0], host_rdata_o[0]); end
    endtask

    initial begin
        cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = 32'hFFF0_0000;
        cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = 32'hFFFF_FC00;
        cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = 32'hFFFF_FC00;
        test_reset();
        test_write();
        test_timer_err();
        test_back_to_back();
        test_two_hosts();
        test_unmapped();
        test_idle_clears();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_bus_xbar.md
Name: simple_bus_xbar

Overview:
- Combinational request crossbar with registered response routing; connects NrHosts bus masters (e.g. the core data port) to NrDevices memory-mapped slaves (RAM, simulator control, timer).
- Uses the OBI-style req/gnt/rvalid protocol.
- Selects one host per cycle by fixed priority and decodes its address against per-device base/mask pairs.
- Routes the single-cycle-latency device response back to the originating host.

Parameters:
- NrDevices, 1, number of slave ports (at least 1).
- NrHosts, 1, number of master ports (at least 1).
- DataWidth, 32, data bus width in bits.
- AddressWidth, 32, address bus width in bits.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- host_req_i  in  1 x [NrHosts]  host request.
- host_gnt_o  out  1 x [NrHosts]  host grant.
- host_addr_i  in  AddressWidth x [NrHosts]  byte address.
- host_we_i  in  1 x [NrHosts]  write enable.
- host_be_i  in  DataWidth/8 x [NrHosts]  byte enables.
- host_wdata_i  in  DataWidth x [NrHosts]  write data.
- host_rvalid_o  out  1 x [NrHosts]  response valid.
- host_rdata_o  out  DataWidth x [NrHosts]  read data.
- host_err_o  out  1 x [NrHosts]  response error.
- device_req_o  out  1 x [NrDevices]  device request.
- device_addr_o  out  AddressWidth x [NrDevices]  address (forwarded unmodified).
- device_we_o  out  1 x [NrDevices]  write enable.
- device_be_o  out  DataWidth/8 x [NrDevices]  byte enables.
- device_wdata_o  out  DataWidth x [NrDevices]  write data.
- device_rvalid_i  in  1 x [NrDevices]  device response valid.
- device_rdata_i  in  DataWidth x [NrDevices]  device read data.
- device_err_i  in  1 x [NrDevices]  device error.
- cfg_device_addr_base  in  AddressWidth x [NrDevices]  device base address.
- cfg_device_addr_mask  in  AddressWidth x [NrDevices]  device address mask.

Behaviour:
- Arbitration (combinational):
  - The lowest-index host with req=1 wins.
  - The winner gets gnt=1 in the same cycle; all other hosts get gnt=0.
  - No fairness; losing hosts keep req asserted and retry.
- Decode (combinational):
  - Device d matches when (host_addr & mask[d]) == base[d].
  - If several devices match, the lowest index wins.
- Request forwarding:
  - Only the selected device sees req=1, carrying the winning host's addr/we/be/wdata.
  - All other devices see req=0.
  - Non-selected device addr/we/be/wdata equal the winning host's values (don't-care); when there is no request they are 0.
- Response path:
  - On a granted cycle, the winning host index and the device index (or an "unmapped" flag) are registered.
  - Devices must respond exactly one cycle after req.
  - host_rvalid/rdata/err of the registered host mirror device_rvalid/rdata/err of the registered device.
  - Other hosts see rvalid=0, err=0, rdata=0.
  - Back-to-back requests are supported: a new request is granted in the same cycle an earlier response returns.
- Reset:
  - Selection registers clear to host 0 / device 0 / unmapped=0.
  - A pending-response flag clears, so all host_rvalid_o=0 and host_err_o=0.
  - Reset asserted mid-transaction drops the outstanding response silently.
  - host_gnt_o remains combinational on host_req_i.
- No-request cycle: all device_req_o=0; the pending flag clears next cycle.

Optional Feature:
- Macro: SIMPLE_BUS_UNMAPPED_ERR_EN.
- Defined: a request matching no device is still granted, with no device_req asserted. The next cycle the host sees rvalid=1, err=1, rdata=0.
- Undefined: an unmapped request is routed to device 0 as if it matched.

Test Plan:
- Map: RAM base 0x100000 / mask 0xFFF00000; SimCtrl base 0x20000 / mask 0xFFFFFC00; Timer base 0x30000 / mask 0xFFFFFC00.
- Host0 write to 0x100010, wdata 0xDEADBEEF, be 0xF -> same cycle host_gnt=1, device_req[0]=1 with addr 0x100010; next cycle RAM rvalid=1 -> host_rvalid=1, err=0.
- Host0 read of 0x30004 with Timer returning rdata 0x1234 and err=1 one cycle later -> host_rdata=0x1234, host_err=1, host_rvalid=1.
- Back-to-back reads of 0x100000 then 0x20008 -> the second response is routed from SimCtrl (device 1), not RAM.
- Two hosts (NrHosts=2) request together -> host0 granted, host1 gnt=0; host1 is granted the following cycle and its response is not visible on host0.
- Read of 0x50000 with the macro defined -> gnt=1, no device_req, next cycle rvalid=1, err=1, rdata=0. Macro undefined -> device_req[0]=1.
- Assert rst_ni low in the cycle after a grant -> host_rvalid_o=0 immediately; after release, idle outputs are all 0.
